// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-wide data memory port.
// Handles one request at a time. Sub-word stores use read-modify-write. Loads are lane-extracted and extended.
module lsu_mem_master #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_is_store,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rdata,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_misaligned,
   output logic             mem_read_en,
   output logic             mem_write_en,
   output logic [31:0]      mem_address,
   output logic [31:0]      mem_write_data,
   input  logic [31:0]      mem_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_RD,
      WRITE,
      RESP
   } state_t;

   state_t state, state_next;

   logic [2:0]       lat_funct3;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   logic [31:0]      merge_word;
   logic [31:0]      rdata_q;
   logic [TAG_W-1:0] tag_q;
   logic             mis_q;

   logic             req_fault;
   logic [31:0]      shifted;
   logic [31:0]      load_ext;
   logic [31:0]      merged;

   // Alignment and funct3 legality are judged on the incoming request so a fault skips memory entirely.
   always_comb begin
      req_fault = 1'b0;
      if (req_is_store) begin
         case (req_funct3)
            3'b000:  req_fault = 1'b0;
            3'b001:  req_fault = req_addr[0];
            3'b010:  req_fault = |req_addr[1:0];
            default: req_fault = 1'b1;
         endcase
      end else begin
         case (req_funct3)
            3'b000, 3'b100: req_fault = 1'b0;
            3'b001, 3'b101: req_fault = req_addr[0];
            3'b010:         req_fault = |req_addr[1:0];
            default:        req_fault = 1'b1;
         endcase
      end
   end

   always_comb begin
      shifted  = mem_read_data >> {lat_addr[1:0], 3'b000};
      load_ext = mem_read_data;
      case (lat_funct3)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_ext = {24'h000000, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_ext = {16'h0000, shifted[15:0]};
         default: load_ext = mem_read_data;
      endcase
   end

   // Overlay the store data onto the lane addressed by the low address bits.
   always_comb begin
      merged = mem_read_data;
      if (lat_funct3 == 3'b000) begin
         case (lat_addr[1:0])
            2'd0:    merged[7:0]   = lat_wdata[7:0];
            2'd1:    merged[15:8]  = lat_wdata[7:0];
            2'd2:    merged[23:16] = lat_wdata[7:0];
            default: merged[31:24] = lat_wdata[7:0];
         endcase
      end else begin
         if (lat_addr[1]) merged[31:16] = lat_wdata[15:0];
         else             merged[15:0]  = lat_wdata[15:0];
      end
   end

   always_comb begin
      state_next     = state;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      mem_read_en    = 1'b0;
      mem_write_en   = 1'b0;
      mem_address    = 32'h0;
      mem_write_data = 32'h0;
      if (state != IDLE) mem_address = {2'b00, lat_addr[31:2]};
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_fault)                  state_next = RESP;
               else if (!req_is_store)         state_next = LOAD;
               else if (req_funct3 == 3'b010)  state_next = WRITE;
               else                            state_next = RMW_RD;
            end
         end
         LOAD: begin
            mem_read_en = 1'b1;
            state_next  = RESP;
         end
         RMW_RD: begin
            mem_read_en = 1'b1;
            state_next  = WRITE;
         end
         WRITE: begin
            mem_write_en   = 1'b1;
            mem_write_data = (lat_funct3 == 3'b010) ? lat_wdata : merge_word;
            state_next     = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         lat_funct3 <= 3'b000;
         lat_addr   <= 32'h0;
         lat_wdata  <= 32'h0;
         merge_word <= 32'h0;
         rdata_q    <= 32'h0;
         tag_q      <= '0;
         mis_q      <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_funct3 <= req_funct3;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  rdata_q    <= 32'h0;
                  tag_q      <= req_tag;
                  mis_q      <= req_fault;
               end
            end
            LOAD:    rdata_q    <= load_ext;
            RMW_RD:  merge_word <= merged;
            default: ;
         endcase
      end
   end

   assign resp_rdata      = rdata_q;
   assign resp_tag        = tag_q;
   assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests push expected responses, a monitor pops and compares.
module tb_lsu_mem_master;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_is_store = 1'b0;
   logic [2:0]       req_funct3 = 3'b000;
   logic [31:0]      req_addr = 32'h0;
   logic [31:0]      req_wdata = 32'h0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             resp_valid;
   logic             resp_ready = 1'b1;
   logic [31:0]      resp_rdata;
   logic [TAG_W-1:0] resp_tag;
   logic             resp_misaligned;
   logic             mem_read_en;
   logic             mem_write_en;
   logic [31:0]      mem_address;
   logic [31:0]      mem_write_data;
   logic [31:0]      mem_read_data;

   always #5 clk = ~clk;

   lsu_mem_master #(.TAG_W(TAG_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_is_store    (req_is_store),
      .req_funct3      (req_funct3),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_tag         (req_tag),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_rdata      (resp_rdata),
      .resp_tag        (resp_tag),
      .resp_misaligned (resp_misaligned),
      .mem_read_en     (mem_read_en),
      .mem_write_en    (mem_write_en),
      .mem_address     (mem_address),
      .mem_write_data  (mem_write_data),
      .mem_read_data   (mem_read_data)
   );

   // Small word memory with combinational read and posedge write.
   logic [31:0] mem [0:63];
   assign mem_read_data = mem[mem_address[5:0]];

   int cycle = 0;
   int rdCnt = 0;
   int wrCnt = 0;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (mem_read_en)  rdCnt <= rdCnt + 1;
      if (mem_write_en) begin
         wrCnt <= wrCnt + 1;
         mem[mem_address[5:0]] <= mem_write_data;
      end
   end

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      rdata;
      logic             mis;
      int               cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: response ordering/content, first-valid cycle, stability under backpressure, busy req_ready.
   logic             prevValid = 1'b0;
   logic             prevHs = 1'b0;
   logic [31:0]      prevRdata = 32'h0;
   logic [TAG_W-1:0] prevTag = '0;
   logic             prevMis = 1'b0;
   int               firstCyc = 0;
   exp_t             e;

   initial begin
      forever begin
         @(negedge clk);
         checkOutput("enables_exclusive", 32'(mem_read_en & mem_write_en), 32'h0);
         if (resp_valid) begin
            if (!prevValid || prevHs) firstCyc = cycle;
            else begin
               checkOutput("stable_rdata", resp_rdata, prevRdata);
               checkOutput("stable_tag", 32'(resp_tag), 32'(prevTag));
               checkOutput("stable_mis", 32'(resp_misaligned), 32'(prevMis));
            end
            checkOutput("req_ready_busy", 32'(req_ready), 32'h0);
            if (resp_ready) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_resp: got tag %0d expected no response", resp_tag);
               end else begin
                  e = sbq.pop_front();
                  checkOutput("resp_tag", 32'(resp_tag), 32'(e.tag));
                  checkOutput("resp_rdata", resp_rdata, e.rdata);
                  checkOutput("resp_mis", 32'(resp_misaligned), 32'(e.mis));
                  checkOutput("resp_cycle", 32'(firstCyc), 32'(e.cyc));
               end
            end
         end
         prevValid = resp_valid;
         prevHs    = resp_valid & resp_ready;
         prevRdata = resp_rdata;
         prevTag   = resp_tag;
         prevMis   = resp_misaligned;
      end
   end

   // Issue one request, push its expected response, wait for the monitor to retire it.
   task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [TAG_W-1:0] tg,
                                input logic [31:0] expRdata, input logic expMis, input int lat,
                                input int expRd, input int expWr, input int hold);
      int rd0, wr0, acc, n;
      @(posedge clk);
      #1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = wd;
      req_tag      = tg;
      req_valid    = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("req_ready_idle", 32'(req_ready), 32'h1);
      rd0 = rdCnt;
      wr0 = wrCnt;
      @(posedge clk);
      #1;
      acc = cycle;
      req_valid = 1'b0;
      sbq.push_back('{tag: tg, rdata: expRdata, mis: expMis, cyc: acc + lat - 1});
      if (hold > 0) begin
         resp_ready = 1'b0;
         n = 0;
         while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         req_valid = 1'b1;
         req_tag   = tg + 4'd1;
         req_addr  = 32'h0000_0020;
         repeat (hold) begin
            @(posedge clk);
            #1;
         end
         req_valid  = 1'b0;
         resp_ready = 1'b1;
      end
      n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL resp_timeout: got no response expected tag %0d", tg);
         sbq.delete();
      end
      checkOutput("read_pulses", 32'(rdCnt - rd0), 32'(expRd));
      checkOutput("write_pulses", 32'(wrCnt - wr0), 32'(expWr));
   endtask

   int wrSnap;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_resp_mis", 32'(resp_misaligned), 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_resp_tag", 32'(resp_tag), 32'h0);
      checkOutput("rst_mem_en", 32'({mem_read_en, mem_write_en}), 32'h0);
      checkOutput("rst_mem_addr", mem_address, 32'h0);
      checkOutput("rst_mem_wdata", mem_write_data, 32'h0);

      // Stores: SW then SB read-modify-write
      applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'd3, 32'h0, 1'b0, 2, 0, 1, 0);
      checkOutput("mem4_after_sw", mem[4], 32'hDEADBEEF);
      applyStimulus(1'b1, 3'b000, 32'h11, 32'h00000055, 4'd5, 32'h0, 1'b0, 3, 1, 1, 0);
      checkOutput("mem4_after_sb", mem[4], 32'hDEAD55EF);

      // Loads with sign/zero extension
      applyStimulus(1'b0, 3'b000, 32'h11, 32'h0, 4'd6,  32'h00000055, 1'b0, 2, 1, 0, 0);
      applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 4'd7,  32'hFFFFFFDE, 1'b0, 2, 1, 0, 0);
      applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 4'd8,  32'hFFFFDEAD, 1'b0, 2, 1, 0, 0);
      applyStimulus(1'b0, 3'b101, 32'h12, 32'h0, 4'd9,  32'h0000DEAD, 1'b0, 2, 1, 0, 0);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 4'd10, 32'hDEAD55EF, 1'b0, 2, 1, 0, 0);

      // Faults: no memory access, immediate response
      applyStimulus(1'b0, 3'b010, 32'h13, 32'h0, 4'd11, 32'h0, 1'b1, 1, 0, 0, 0);
      applyStimulus(1'b1, 3'b001, 32'h11, 32'h1234, 4'd12, 32'h0, 1'b1, 1, 0, 0, 0);
      applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 4'd13, 32'h0, 1'b1, 1, 0, 0, 0);
      applyStimulus(1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 4'd14, 32'h0, 1'b1, 1, 0, 0, 0);
      checkOutput("mem4_after_faults", mem[4], 32'hDEAD55EF);

      // Backpressure on an LW response with a competing request
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 4'd2, 32'hDEAD55EF, 1'b0, 2, 1, 0, 3);

      // SH into upper half, then byte and halfword unsigned loads
      applyStimulus(1'b1, 3'b001, 32'h12, 32'hABCD1234, 4'd1, 32'h0, 1'b0, 3, 1, 1, 0);
      checkOutput("mem4_after_sh", mem[4], 32'h123455EF);
      applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 4'd0, 32'h00000012, 1'b0, 2, 1, 0, 0);
      applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, 4'd4, 32'h000055EF, 1'b0, 2, 1, 0, 0);

      // Reset while an SB is in RMW_RD: no write, no response
      @(posedge clk);
      #1;
      req_is_store = 1'b1;
      req_funct3   = 3'b000;
      req_addr     = 32'h20;
      req_wdata    = 32'h77;
      req_tag      = 4'd15;
      req_valid    = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b0;
      wrSnap    = wrCnt;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("midrst_req_ready", 32'(req_ready), 32'h1);
      checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midrst_no_write", 32'(wrCnt - wrSnap), 32'h0);
      checkOutput("midrst_mem8", mem[8], 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 4'd6, 32'h123455EF, 1'b0, 2, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
